// File: rtl/ir_pair_scan_seq.sv
// IR sensor-pair scan sequencer: per pair, emitter enable, settle, right/left A2D conversions,
// and a position-weighted saturated signed line-error accumulated over one scan.
module ir_pair_scan_seq #(
    parameter int unsigned NUM_PAIRS      = 3,
    parameter int unsigned RES_W          = 12,
    parameter int unsigned ERR_W          = 16,
    parameter int unsigned SETTLE_CYCLES  = 4096,
    parameter int unsigned GAP_CYCLES     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned WEIGHT_SHIFT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 cnv_cmplt,
    input  logic [RES_W-1:0]     A2D_res,
    output logic                 start_conv,
    output logic [2:0]           chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [ERR_W-1:0]     err,
    output logic                 err_vld,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned PAIR_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES)
                                    ? ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES)
                                    : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Two guard bits keep the pre-saturation sum exact for any shifted difference.
    localparam int unsigned SUM_W   = ERR_W + 2;

    typedef enum logic [3:0] {
        IDLE, SETTLE, START_R, WAIT_R, GAP, START_L, WAIT_L, ACCUM, DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [PAIR_W-1:0]        pair, pair_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [RES_W-1:0]         res_r, res_r_nxt, res_l, res_l_nxt;
    logic signed [ERR_W-1:0]  acc, acc_nxt;
    logic [ERR_W-1:0]         err_nxt;
    logic                     err_vld_nxt, start_conv_nxt, busy_nxt, timeout_nxt;
    logic [2:0]               chnnl_nxt;
    logic [NUM_PAIRS-1:0]     ir_en_nxt;

    logic signed [RES_W:0]    diff;
    logic signed [ERR_W:0]    diff_ext, diff_w;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ERR_W-1:0]  sat;
    logic [7:0]               shamt;

    // Weighted difference of the current pair added to the accumulator, clamped to ERR_W.
    always_comb begin
        diff     = $signed({1'b0, res_r}) - $signed({1'b0, res_l});
        diff_ext = (ERR_W+1)'(diff);
        shamt    = 8'(32'(pair) * WEIGHT_SHIFT);
        diff_w   = diff_ext <<< shamt;
        sum      = SUM_W'(acc) + SUM_W'(diff_w);
        if ((sum[SUM_W-1:ERR_W-1] == '0) || (sum[SUM_W-1:ERR_W-1] == '1)) begin
            sat = sum[ERR_W-1:0];
        end else if (sum[SUM_W-1]) begin
            sat = {1'b1, {(ERR_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(ERR_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_nxt      = state;
        pair_nxt       = pair;
        cnt_nxt        = cnt;
        res_r_nxt      = res_r;
        res_l_nxt      = res_l;
        acc_nxt        = acc;
        err_nxt        = err;
        timeout_nxt    = timeout;
        ir_en_nxt      = IR_en;
        chnnl_nxt      = chnnl;
        start_conv_nxt = 1'b0;
        err_vld_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                ir_en_nxt = '0;
                if (go) begin
                    state_nxt   = SETTLE;
                    pair_nxt    = '0;
                    ir_en_nxt   = NUM_PAIRS'(1);
                    acc_nxt     = '0;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt      = START_R;
                    start_conv_nxt = 1'b1;
                    chnnl_nxt      = 3'(pair) << 1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            START_R: begin
                state_nxt = WAIT_R;
                cnt_nxt   = '0;
            end
            WAIT_R: begin
                if (cnv_cmplt) begin
                    res_r_nxt = A2D_res;
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_nxt = 1'b1;
                    ir_en_nxt   = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt      = START_L;
                    start_conv_nxt = 1'b1;
                    chnnl_nxt      = (3'(pair) << 1) | 3'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            START_L: begin
                state_nxt = WAIT_L;
                cnt_nxt   = '0;
            end
            WAIT_L: begin
                if (cnv_cmplt) begin
                    res_l_nxt = A2D_res;
                    state_nxt = ACCUM;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_nxt = 1'b1;
                    ir_en_nxt   = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ACCUM: begin
                acc_nxt   = sat;
                ir_en_nxt = '0;
                if (pair == PAIR_W'(NUM_PAIRS - 1)) begin
                    // err and err_vld are registered, so they become visible while in DONE.
                    state_nxt   = DONE;
                    err_nxt     = sat;
                    err_vld_nxt = 1'b1;
                end else begin
                    pair_nxt  = pair + PAIR_W'(1);
                    ir_en_nxt = NUM_PAIRS'(1) << pair_nxt;
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pair       <= '0;
            cnt        <= '0;
            res_r      <= '0;
            res_l      <= '0;
            acc        <= '0;
            err        <= '0;
            err_vld    <= 1'b0;
            start_conv <= 1'b0;
            chnnl      <= '0;
            IR_en      <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pair       <= pair_nxt;
            cnt        <= cnt_nxt;
            res_r      <= res_r_nxt;
            res_l      <= res_l_nxt;
            acc        <= acc_nxt;
            err        <= err_nxt;
            err_vld    <= err_vld_nxt;
            start_conv <= start_conv_nxt;
            chnnl      <= chnnl_nxt;
            IR_en      <= ir_en_nxt;
            busy       <= busy_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule
